// File: rtl/wb_pkg.sv
// Shared types and width helpers for the queued Wishbone master.
// Command words are packed as {we, adr, dat}, CMD_W = 1 + ADDR_W + DATA_W.
package wb_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    function automatic int unsigned cmd_width(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Width of the ack-timeout counter; never narrower than one bit.
    function automatic int unsigned timeout_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO with a first-word-fall-through head.
// Pointers wrap modulo DEPTH (a power of two); count is one bit wider.
module wb_cmd_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wishbone_master_queued.sv
// Wishbone B4 classic master: queues commands, runs them one at a time in order,
// and returns a tagged response with read data and a timeout error flag.
module wishbone_master_queued
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmdValid,
    output logic              o_cmdReady,
    input  logic              i_cmdWrite,
    input  logic [ADDR_W-1:0] i_cmdAddr,
    input  logic [DATA_W-1:0] i_cmdData,
    output logic              o_rspValid,
    output logic [DATA_W-1:0] o_rspData,
    output logic              o_rspErr,
    output logic              o_busy,
    output logic              o_wbCyc,
    output logic              o_wbStb,
    output logic              o_wbWe,
    output logic [ADDR_W-1:0] o_wbAdr,
    output logic [DATA_W-1:0] o_wbDat,
    input  logic [DATA_W-1:0] i_wbDat,
    input  logic              i_wbAck
);

    localparam int unsigned CMD_W = cmd_width(ADDR_W, DATA_W);
    localparam int unsigned TO_W  = timeout_width(TIMEOUT);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CMD_W-1:0] fifo_head;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic              head_we;
    logic [ADDR_W-1:0] head_adr;
    logic [DATA_W-1:0] head_dat;

    state_t            state_q,     state_d;
    logic              cyc_q,       cyc_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] adr_q,       adr_d;
    logic [DATA_W-1:0] dat_q,       dat_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              timeout_hit;

    wb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push    (i_cmdValid),
        .wr_data ({i_cmdWrite, i_cmdAddr, i_cmdData}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_we  = fifo_head[CMD_W-1];
    assign head_adr = fifo_head[DATA_W +: ADDR_W];
    assign head_dat = fifo_head[DATA_W-1:0];

    // A zero TIMEOUT never expires.
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        to_cnt_d    = to_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                adr_d = '0;
                dat_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cyc_d    = 1'b1;
                    we_d     = head_we;
                    adr_d    = head_adr;
                    dat_d    = head_dat;
                    to_cnt_d = '0;
                    state_d  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Ack takes priority over a timeout expiring on the same edge.
                if (i_wbAck) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = we_q ? '0 : i_wbDat;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_cmdReady = !fifo_full;
    assign o_busy     = (fifo_count != '0) || (state_q == S_ACTIVE);
    assign o_wbCyc    = cyc_q;
    assign o_wbStb    = cyc_q;
    assign o_wbWe     = we_q;
    assign o_wbAdr    = adr_q;
    assign o_wbDat    = dat_q;
    assign o_rspValid = rsp_valid_q;
    assign o_rspData  = rsp_data_q;
    assign o_rspErr   = rsp_err_q;

endmodule

// File: tb/tb_wishbone_master_queued.sv
// Bench for wishbone_master_queued: transaction-level queue model checked every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_wishbone_master_queued;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 8;

    typedef struct packed {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
    } cmd_t;

    logic       clk;
    logic       rst;
    logic       i_cmdValid;
    logic       o_cmdReady;
    logic       i_cmdWrite;
    logic [7:0] i_cmdAddr;
    logic [7:0] i_cmdData;
    logic       o_rspValid;
    logic [7:0] o_rspData;
    logic       o_rspErr;
    logic       o_busy;
    logic       o_wbCyc;
    logic       o_wbStb;
    logic       o_wbWe;
    logic [7:0] o_wbAdr;
    logic [7:0] o_wbDat;
    logic [7:0] i_wbDat;
    logic       i_wbAck;

    int total = 0;
    int bad   = 0;

    wishbone_master_queued #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cmdValid (i_cmdValid),
        .o_cmdReady (o_cmdReady),
        .i_cmdWrite (i_cmdWrite),
        .i_cmdAddr  (i_cmdAddr),
        .i_cmdData  (i_cmdData),
        .o_rspValid (o_rspValid),
        .o_rspData  (o_rspData),
        .o_rspErr   (o_rspErr),
        .o_busy     (o_busy),
        .o_wbCyc    (o_wbCyc),
        .o_wbStb    (o_wbStb),
        .o_wbWe     (o_wbWe),
        .o_wbAdr    (o_wbAdr),
        .o_wbDat    (o_wbDat),
        .i_wbDat    (i_wbDat),
        .i_wbAck    (i_wbAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Slave register contents; address 0xEE models a hung slave.
    function automatic logic [7:0] slave_data(input logic [7:0] a);
        return (a == 8'h4D) ? 8'hA7 : (a ^ 8'hC3);
    endfunction

    int ack_lat = 0;
    bit stray   = 1'b0;
    int hi_cnt  = 0;

    // Slave: acks once stb has been high for ack_lat cycles (0 = never).
    always @(posedge clk) begin
        #1;
        if (rst) begin
            hi_cnt  = 0;
            i_wbAck = 1'b0;
        end else begin
            hi_cnt  = o_wbStb ? hi_cnt + 1 : 0;
            i_wbAck = stray || (o_wbStb && ack_lat != 0 && hi_cnt == ack_lat && o_wbAdr != 8'hEE);
        end
        i_wbDat = slave_data(o_wbAdr);
    end

    // Behavioural model: pending queue, one active transaction, age in bus cycles.
    cmd_t       mq[$];
    cmd_t       m_cur;
    bit         m_act = 1'b0;
    int         m_age = 0;
    bit         m_rv  = 1'b0;
    logic [7:0] m_rd  = 8'h00;
    bit         m_re  = 1'b0;
    bit         m_was;
    bit         m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_act = 1'b0;
            m_age = 0;
            m_rv  = 1'b0;
            m_rd  = 8'h00;
            m_re  = 1'b0;
        end else begin
            m_was = m_act;
            m_acc = i_cmdValid && (mq.size() < DEPTH);
            m_rv  = 1'b0;
            if (m_was) begin
                m_age++;
                if (i_wbAck) begin
                    m_act = 1'b0;
                    m_rv  = 1'b1;
                    m_re  = 1'b0;
                    m_rd  = m_cur.we ? 8'h00 : slave_data(m_cur.adr);
                end else if (m_age == TO) begin
                    m_act = 1'b0;
                    m_rv  = 1'b1;
                    m_re  = 1'b1;
                    m_rd  = 8'h00;
                end
            end else if (mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_age = 0;
            end
            if (m_acc) mq.push_back({i_cmdWrite, i_cmdAddr, i_cmdData});
        end
    end

    always @(negedge clk) begin
        chk("cyc",      32'(o_wbCyc),    32'(m_act));
        chk("stb",      32'(o_wbStb),    32'(m_act));
        chk("we",       32'(o_wbWe),     32'(m_act ? m_cur.we : 1'b0));
        chk("adr",      32'(o_wbAdr),    32'(m_act ? m_cur.adr : 8'h00));
        chk("dat",      32'(o_wbDat),    32'(m_act ? m_cur.dat : 8'h00));
        chk("rsp_valid", 32'(o_rspValid), 32'(m_rv));
        chk("rsp_data", 32'(o_rspData),  32'(m_rd));
        chk("rsp_err",  32'(o_rspErr),   32'(m_re));
        chk("ready",    32'(o_cmdReady), 32'(mq.size() < DEPTH));
        chk("busy",     32'(o_busy),     32'(m_act || mq.size() > 0));
    end

    logic [8:0] rsp_log[$];
    int         runs[$];
    int         run = 0;

    always @(negedge clk) begin
        if (o_rspValid) rsp_log.push_back({o_rspErr, o_rspData});
        if (rst) run = 0;
        else if (o_wbCyc) run++;
        else if (run > 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    task automatic chk_rsp(input string nm, input int idx, input logic err, input logic [7:0] d);
        chk(nm, (idx < rsp_log.size()) ? 32'(rsp_log[idx]) : 32'hDEAD, 32'({err, d}));
    endtask

    task automatic chk_run(input string nm, input int idx, input int len);
        chk(nm, (idx < runs.size()) ? 32'(runs[idx]) : 32'hDEAD, 32'(len));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
        bit r;
        int n;
        n = 0;
        i_cmdValid = 1'b1;
        i_cmdWrite = we;
        i_cmdAddr  = a;
        i_cmdData  = d;
        do begin
            r = o_cmdReady;
            step(1);
            n++;
        end while (!r && n < 200);
        if (!r) chk("push_accept", 32'(r), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_cmdValid = 1'b0;
        while (o_busy && n < 500) begin
            step(1);
            n++;
        end
        chk("drain", 32'(o_busy), 32'd0);
        step(2);
    endtask

    task automatic clear_logs();
        rsp_log.delete();
        runs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_cmdValid = 1'b0;
        i_cmdWrite = 1'b0;
        i_cmdAddr  = 8'h00;
        i_cmdData  = 8'h00;
        i_wbAck    = 1'b0;
        i_wbDat    = 8'h00;
        #18;
        chk("rst_cyc",   32'(o_wbCyc),    32'd0);
        chk("rst_ready", 32'(o_cmdReady), 32'd1);
        chk("rst_busy",  32'(o_busy),     32'd0);
        chk("rst_rv",    32'(o_rspValid), 32'd0);
        chk("rst_rdata", 32'(o_rspData),  32'd0);
        #4 rst = 1'b0;
        step(1);

        // Single write, ack three cycles into the strobe.
        clear_logs();
        ack_lat = 3;
        push(1'b1, 8'h4A, 8'h5C);
        i_cmdValid = 1'b0;
        step(1);
        chk("wr_cyc", 32'(o_wbCyc), 32'd1);
        chk("wr_bus", 32'({o_wbWe, o_wbAdr, o_wbDat}), 32'h14A5C);
        drain();
        chk("wr_nrsp", 32'(rsp_log.size()), 32'd1);
        chk_rsp("wr_rsp", 0, 1'b0, 8'h00);
        chk_run("wr_run", 0, 3);

        // Read returning 0xA7.
        clear_logs();
        ack_lat = 2;
        push(1'b0, 8'h4D, 8'h99);
        drain();
        chk_rsp("rd_rsp", 0, 1'b0, 8'hA7);

        // Fill the queue while the slave is slow.
        clear_logs();
        ack_lat = 6;
        push(1'b1, 8'h10, 8'h11);
        push(1'b0, 8'h4D, 8'h00);
        push(1'b1, 8'h12, 8'h13);
        push(1'b0, 8'h20, 8'h00);
        push(1'b1, 8'h30, 8'h31);
        i_cmdValid = 1'b0;
        chk("full_ready", 32'(o_cmdReady), 32'd0);
        drain();
        chk("full_nrsp", 32'(rsp_log.size()), 32'd5);
        chk_rsp("full_rsp0", 0, 1'b0, 8'h00);
        chk_rsp("full_rsp1", 1, 1'b0, 8'hA7);
        chk_rsp("full_rsp2", 2, 1'b0, 8'h00);
        chk_rsp("full_rsp3", 3, 1'b0, 8'hE3);
        chk_rsp("full_rsp4", 4, 1'b0, 8'h00);

        // Hung slave times out; the next queued command still runs.
        clear_logs();
        ack_lat = 2;
        push(1'b0, 8'hEE, 8'h00);
        push(1'b0, 8'h21, 8'h00);
        drain();
        chk_run("to_run", 0, 8);
        chk_rsp("to_rsp0", 0, 1'b1, 8'h00);
        chk_rsp("to_rsp1", 1, 1'b0, 8'hE2);
        chk_run("to_run1", 1, 2);

        // Ack on the expiry edge wins; one cycle later it is too late.
        clear_logs();
        ack_lat = 8;
        push(1'b0, 8'h4D, 8'h00);
        drain();
        chk_rsp("edge_rsp", 0, 1'b0, 8'hA7);
        chk_run("edge_run", 0, 8);
        clear_logs();
        ack_lat = 9;
        push(1'b0, 8'h4D, 8'h00);
        drain();
        chk_rsp("late_rsp", 0, 1'b1, 8'h00);

        // Stray ack while idle.
        clear_logs();
        stray = 1'b1;
        step(3);
        stray = 1'b0;
        step(2);
        chk("stray_nrsp", 32'(rsp_log.size()), 32'd0);
        chk("stray_cyc", 32'(o_wbCyc), 32'd0);

        // Reset during an active transaction with two commands queued.
        clear_logs();
        ack_lat = 2;
        push(1'b0, 8'hEE, 8'h00);
        push(1'b1, 8'h40, 8'h41);
        push(1'b0, 8'h42, 8'h00);
        i_cmdValid = 1'b0;
        step(2);
        chk("mid_cyc_pre", 32'(o_wbCyc), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_cyc",   32'(o_wbCyc),    32'd0);
        chk("mid_stb",   32'(o_wbStb),    32'd0);
        chk("mid_busy",  32'(o_busy),     32'd0);
        chk("mid_ready", 32'(o_cmdReady), 32'd1);
        step(2);
        #1 rst = 1'b0;
        step(4);
        chk("post_ready", 32'(o_cmdReady), 32'd1);
        chk("post_busy",  32'(o_busy),     32'd0);
        chk("post_nrsp",  32'(rsp_log.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
